fix_tv_extractor: RTL

Parametrised tag/value extractor for the FIX parser datapath. It accepts the raw FIX byte stream and finds field boundaries itself, splitting on `=` and SOH instead of relying on upstream start strobes. Each completed field is emitted as one record (tag, value, value length, flags) on a valid/ready interface. The block also flags start-of-message (tag 8) and end-of-message (tag 10), and verifies the tag-10 checksum.

---
 rtl/fix_tv_extractor.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/fix_tv_extractor.sv
// fix_tv_extractor
// Splits a raw FIX byte stream into tag/value records. Field boundaries are found
// from the '=' separator and the SOH terminator. Each completed field is presented
// as one record on a single-slot valid/ready output. The block also tracks the
// running message checksum and verifies it against the tag-10 trailer.
//
// Ports:
//   clk, rst           single clock, synchronous active-high reset
//   data_i             stream byte, accepted when in_valid_i & in_ready_o
//   in_valid_i         data_i qualifier
//   in_ready_o         high when the output slot is empty or being drained
//   out_valid_o        record valid, consumed when out_valid_o & out_ready_i
//   out_ready_i        downstream ready
//   tag_o              right-justified ASCII tag (last digit in [7:0])
//   value_o            right-justified ASCII value (last kept byte in [7:0])
//   value_len_o        number of value bytes kept
//   start_of_header_o  record tag is "8"
//   end_of_body_o      record tag is "10"
//   err_o              [0] tag error, [1] truncated, [2] checksum bad, [3] empty value
module fix_tv_extractor #(
    parameter int         TAG_BYTES = 4,
    parameter int         VAL_BYTES = 32,
    parameter logic [7:0] SOH_CHAR  = 8'h01,
    parameter logic [7:0] EQ_CHAR   = 8'h3D
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [7:0]                     data_i,
    input  logic                           in_valid_i,
    output logic                           in_ready_o,
    output logic                           out_valid_o,
    input  logic                           out_ready_i,
    output logic [8*TAG_BYTES-1:0]         tag_o,
    output logic [8*VAL_BYTES-1:0]         value_o,
    output logic [$clog2(VAL_BYTES+1)-1:0] value_len_o,
    output logic                           start_of_header_o,
    output logic                           end_of_body_o,
    output logic [3:0]                     err_o
);
    localparam int TW    = 8 * TAG_BYTES;
    localparam int VW    = 8 * VAL_BYTES;
    localparam int LEN_W = $clog2(VAL_BYTES + 1);
    localparam int CNT_W = $clog2(TAG_BYTES + 1);
    localparam logic [CNT_W-1:0] TAG_MAX = CNT_W'(TAG_BYTES);
    localparam logic [LEN_W-1:0] VAL_MAX = LEN_W'(VAL_BYTES);
    localparam logic [TW-1:0]    TAG_8   = TW'(8'h38);
    localparam logic [TW-1:0]    TAG_10  = TW'(16'h3130);

    typedef enum logic [1:0] {
        S_TAG  = 2'd0,
        S_VAL  = 2'd1,
        S_SKIP = 2'd2
    } state_t;

    function automatic logic is_digit(input logic [7:0] b);
        return (b >= 8'h30) && (b <= 8'h39);
    endfunction

    // Three ASCII digits given as their low nibbles -> binary 0..999.
    function automatic logic [9:0] dec3(input logic [3:0] h, input logic [3:0] t,
                                        input logic [3:0] o);
        logic [9:0] hv;
        logic [9:0] tv;
        logic [9:0] ov;
        hv = {6'd0, h};
        tv = {6'd0, t};
        ov = {6'd0, o};
        return hv * 10'd100 + tv * 10'd10 + ov;
    endfunction

    state_t           state_r;
    logic [TW-1:0]    tag_r;
    logic [CNT_W-1:0] tag_cnt_r;
    logic [VW-1:0]    value_r;
    logic [LEN_W-1:0] len_r;
    logic             trunc_r;
    logic [7:0]       field_sum_r;
    logic [7:0]       msg_sum_r;

    logic       accept_s;
    logic       emit_s;
    logic       bad_rec_s;
    logic [7:0] fsum_next_s;
    logic       tag_is_8_s;
    logic       tag_is_10_s;
    logic       cks_ok_s;
    logic [3:0] rec_err_s;

    assign in_ready_o  = !out_valid_o || out_ready_i;
    assign accept_s    = in_valid_i && in_ready_o;
    assign fsum_next_s = field_sum_r + data_i;
    // Every SOH closes a field; only a field that reached S_VAL has a usable tag.
    assign emit_s      = accept_s && (data_i == SOH_CHAR);
    assign bad_rec_s   = (state_r != S_VAL);
    assign tag_is_8_s  = (tag_r == TAG_8);
    assign tag_is_10_s = (tag_r == TAG_10);
    assign cks_ok_s    = (len_r == LEN_W'(3))
                       && is_digit(value_r[23:16]) && is_digit(value_r[15:8])
                       && is_digit(value_r[7:0])
                       && (dec3(value_r[19:16], value_r[11:8], value_r[3:0])
                           == {2'b00, msg_sum_r});

    // Error flags of the record being completed by the current SOH.
    always_comb begin
        rec_err_s = 4'b0000;
        if (bad_rec_s) begin
            rec_err_s = 4'b0001;
        end else begin
            rec_err_s = {(len_r == {LEN_W{1'b0}}), (tag_is_10_s && !cks_ok_s), trunc_r, 1'b0};
        end
    end

    // Field parser, checksum accumulation and single-slot output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r           <= S_TAG;
            tag_r             <= {TW{1'b0}};
            tag_cnt_r         <= {CNT_W{1'b0}};
            value_r           <= {VW{1'b0}};
            len_r             <= {LEN_W{1'b0}};
            trunc_r           <= 1'b0;
            field_sum_r       <= 8'h00;
            msg_sum_r         <= 8'h00;
            out_valid_o       <= 1'b0;
            tag_o             <= {TW{1'b0}};
            value_o           <= {VW{1'b0}};
            value_len_o       <= {LEN_W{1'b0}};
            start_of_header_o <= 1'b0;
            end_of_body_o     <= 1'b0;
            err_o             <= 4'b0000;
        end else begin
            // Output slot: a new record replaces a consumed one without a bubble.
            if (emit_s) begin
                out_valid_o       <= 1'b1;
                tag_o             <= bad_rec_s ? {TW{1'b0}} : tag_r;
                value_o           <= bad_rec_s ? {VW{1'b0}} : value_r;
                value_len_o       <= bad_rec_s ? {LEN_W{1'b0}} : len_r;
                start_of_header_o <= !bad_rec_s && tag_is_8_s;
                end_of_body_o     <= !bad_rec_s && tag_is_10_s;
                err_o             <= rec_err_s;
            end else if (out_ready_i) begin
                out_valid_o <= 1'b0;
            end else begin
                out_valid_o <= out_valid_o;
            end

            if (emit_s) begin
                // Tag 8 restarts the message sum, tag 10 only checks it.
                if (!bad_rec_s && tag_is_8_s) begin
                    msg_sum_r <= fsum_next_s;
                end else if (!bad_rec_s && !tag_is_10_s) begin
                    msg_sum_r <= msg_sum_r + fsum_next_s;
                end else begin
                    msg_sum_r <= msg_sum_r;
                end
                state_r     <= S_TAG;
                tag_r       <= {TW{1'b0}};
                tag_cnt_r   <= {CNT_W{1'b0}};
                value_r     <= {VW{1'b0}};
                len_r       <= {LEN_W{1'b0}};
                trunc_r     <= 1'b0;
                field_sum_r <= 8'h00;
            end else if (accept_s) begin
                field_sum_r <= fsum_next_s;
                case (state_r)
                    S_TAG: begin
                        if (is_digit(data_i) && (tag_cnt_r != TAG_MAX)) begin
                            tag_r     <= {tag_r[TW-9:0], data_i};
                            tag_cnt_r <= tag_cnt_r + CNT_W'(1);
                        end else if ((data_i == EQ_CHAR) && (tag_cnt_r != {CNT_W{1'b0}})) begin
                            state_r <= S_VAL;
                        end else begin
                            state_r <= S_SKIP;
                        end
                    end
                    S_VAL: begin
                        if (len_r != VAL_MAX) begin
                            value_r <= {value_r[VW-9:0], data_i};
                            len_r   <= len_r + LEN_W'(1);
                        end else begin
                            trunc_r <= 1'b1;
                        end
                    end
                    S_SKIP: begin
                        state_r <= S_SKIP;
                    end
                    default: begin
                        state_r <= S_TAG;
                    end
                endcase
            end else begin
                state_r <= state_r;
            end
        end
    end
endmodule
